rpn_sequencer: RTL and testbench
================================

# rpn_sequencer

Front-end driver for the 8-bit stack calculator (`main`). It accepts a stream of reverse-Polish tokens over a valid/ready handshake and turns each token into one `in`/`op`/`apply` command for the calculator. After each command it reads back `tail`, `valid` and `empty`. At the end of each expression it returns one result, or one error code, over a second valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 8, operand/result width; must match the calculator.
- `DEPTH`, 5, calculator stack capacity, used for local overflow checking.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tok_valid`  in  1  token offered.
- `tok_ready`  out  1  token accepted on an edge where `tok_valid && tok_ready`.
- `tok_kind`  in  2  token kind: 0 = operand, 1 = operator, 2 = end-of-expression, 3 = illegal.
- `tok_data`  in  DATA_W  operand value, or operator code in bits [2:0].
- `calc_in`  out  DATA_W  drives the calculator `in` port.
- `calc_op`  out  3  drives the calculator `op` port.
- `calc_apply`  out  1  drives the calculator `apply` port.
- `calc_reset`  out  1  drives the calculator reset (active-high).
- `calc_tail`  in  DATA_W  calculator `tail` output.
- `calc_valid`  in  1  calculator `valid` output.
- `calc_empty`  in  1  calculator `empty` output.
- `res_valid`  out  1  result offered.
- `res_ready`  in  1  result consumed on an edge where `res_valid && res_ready`.
- `res_data`  out  DATA_W  result value; 0 when `res_err` ≠ 0.
- `res_err`  out  2  error code: 0 = ok, 1 = stack underflow or bad final depth, 2 = overflow, 3 = arithmetic fault or illegal token.

## Operation
- Calculator op codes used: 0 push, 1 pop, 2 add, 3 mul, 4 sub, 5 div, 6 mod.
- For binary operators, the top of stack (latest push) is the left operand: push 7, push 86, div gives 12.
- The block keeps a local depth counter `dep` (0..DEPTH).

States:
- **IDLE**
  - `tok_ready=1`.
  - Operand: if `dep==DEPTH`, go to ERR with code 2. Otherwise latch it, go to ISSUE.
  - Operator: codes 2..6 go to ERR with code 1 if `dep<2`, otherwise ISSUE. Any other code, or `tok_kind==3`, goes to ERR with code 3.
  - End: if `dep!=1`, go to ERR with code 1. Otherwise go to POP.
- **ISSUE** (1 cycle)
  - `calc_apply=1`; `calc_op`/`calc_in` come from the latched token.
  - Update `dep`: +1 for push, −1 for an operator.
  - Next state: CHECK.
- **CHECK** (1 cycle)
  - If `calc_valid==0`, go to ERR with code 3 (e.g. divide/mod by 0). Otherwise return to IDLE.
- **POP** (1 cycle)
  - Latch `calc_tail` into `res_data`.
  - Drive `calc_apply=1`, `calc_op=1`; set `dep=0`.
  - Next state: DONE.
- **ERR** (1 cycle)
  - `calc_reset=1`; `dep=0`; `res_data=0`; `res_err` = the code.
  - Next state: DONE.
- **DONE**
  - `res_valid=1`; `res_data`/`res_err` are held stable.
  - On handshake: go to IDLE if the result was ok, or if the error was raised by an end token. Otherwise go to DRAIN.
- **DRAIN**
  - `tok_ready=1`; tokens are discarded.
  - Accepting an end token returns to IDLE.

Outputs:
- `calc_apply` is 0 in every state other than ISSUE and POP.
- `calc_reset` is asserted whenever `reset==0` or the state is ERR.

## Timing
- Reset values (held while `reset==0`):
  - state IDLE, `dep=0`
  - `tok_ready=1`
  - `calc_apply=0`, `calc_op=0`, `calc_in=0`, `calc_reset=1`
  - `res_valid=0`, `res_data=0`, `res_err=0`
- Token pacing:
  - Operand/operator tokens cost 3 cycles (IDLE→ISSUE→CHECK).
  - With back-to-back tokens, `tok_ready` is high 1 cycle in 3.
- Latency: the end token is accepted at edge E. POP happens in cycle E..E+1, and `res_valid` rises after edge E+1.
- Error latency: `res_valid` rises 1 cycle after entering ERR.
- `res_valid` stays high with stable data until `res_ready`, with no time-out. Tokens are not accepted while in DONE.
- Reset mid-operation (any state) returns the block to reset values immediately and clears the calculator. A pending result is lost.
- Simultaneous events:
  - `tok_valid` is ignored outside IDLE and DRAIN.
  - Overflow is detected locally before the push is issued, so the calculator never sees a 6th push.

## Test plan
- Push 4, push 4, op 2, end → `res_data=8`, `res_err=0`; calculator `empty=1` after POP; `tok_ready` duty is 1/3.
- Push 7, push 86, op 5, end → 12. Then push 7, push 86, op 6, end → 2. Then push 4, push 4, op 4, end → 0.
- Push 0, push 86, op 5 → `calc_valid` low in CHECK; ERR pulses `calc_reset` for 1 cycle; `res_err=3`. Next tokens up to and including end are drained, then push 4, end → 4.
- Six pushes → `res_err=2` without a 6th `calc_apply`. Push 4, op 2 → `res_err=1`. Push 4, push 4, end → `res_err=1`, with no drain afterwards.
- Hold `res_ready=0` for 5 cycles after a result → `res_valid`/`res_data` are held and `tok_ready=0`; release → IDLE.
- Assert `reset` low during ISSUE → `calc_apply=0`, `calc_reset=1`, `res_valid=0` at once; after release, push 9, end → 9.

Source files
------------

// File: rtl/rpn_sequencer.sv
// RPN token front-end for the 8-bit stack calculator.
// Issues one calculator command per token and returns one result per expression.
module rpn_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [1:0]        tok_kind,
  input  logic [DATA_W-1:0] tok_data,
  output logic [DATA_W-1:0] calc_in,
  output logic [2:0]        calc_op,
  output logic              calc_apply,
  output logic              calc_reset,
  input  logic [DATA_W-1:0] calc_tail,
  input  logic              calc_valid,
  input  logic              calc_empty,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_err
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_POP,
    S_ERR, S_DONE, S_DRAIN
  } state_t;

  state_t            r_state, w_next;
  logic [DW-1:0]     r_dep;
  logic [DATA_W-1:0] r_in, r_res_data;
  logic [2:0]        r_op;
  logic [1:0]        r_res_err, w_code;
  logic              r_end_err, w_end_err;
  logic              w_to_err, w_latch;
  logic [2:0]        w_opc;
  logic              w_binop;
  logic              w_unused;

  assign w_opc    = tok_data[2:0];
  assign w_binop  = (w_opc >= 3'd2) && (w_opc <= 3'd6);
  assign w_unused = calc_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_code    = 2'd0;
    w_to_err  = 1'b0;
    w_end_err = 1'b0;
    w_latch   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tok_valid) begin
          unique case (1'b1)
            tok_kind == 2'd0: begin
              if (r_dep == DW'(DEPTH)) begin
                w_to_err = 1'b1;
                w_code   = 2'd2;
              end else begin
                w_latch = 1'b1;
                w_next  = S_ISSUE;
              end
            end
            tok_kind == 2'd1: begin
              if (!w_binop) begin
                w_to_err = 1'b1;
                w_code   = 2'd3;
              end else if (r_dep < DW'(2)) begin
                w_to_err = 1'b1;
                w_code   = 2'd1;
              end else begin
                w_latch = 1'b1;
                w_next  = S_ISSUE;
              end
            end
            tok_kind == 2'd2: begin
              if (r_dep != DW'(1)) begin
                w_to_err  = 1'b1;
                w_code    = 2'd1;
                w_end_err = 1'b1;
              end else begin
                w_next = S_POP;
              end
            end
            default: begin
              w_to_err = 1'b1;
              w_code   = 2'd3;
            end
          endcase
        end
      end
      S_ISSUE: w_next = S_CHECK;
      S_CHECK: begin
        if (!calc_valid) begin
          w_to_err = 1'b1;
          w_code   = 2'd3;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_POP: w_next = S_DONE;
      S_ERR: w_next = S_DONE;
      S_DONE: begin
        // Errors raised by an end token already consumed the whole expression
        if (res_ready)
          w_next = (r_res_err == 2'd0 || r_end_err) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (tok_valid && tok_kind == 2'd2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_to_err) w_next = S_ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dep      <= '0;
      r_in       <= '0;
      r_op       <= 3'd0;
      r_res_data <= '0;
      r_res_err  <= 2'd0;
      r_end_err  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_in <= tok_data;
        r_op <= (tok_kind == 2'd0) ? 3'd0 : w_opc;
      end
      if (w_to_err) begin
        r_res_err <= w_code;
        r_end_err <= w_end_err;
      end
      unique case (r_state)
        S_ISSUE: begin
          if (r_op == 3'd0) r_dep <= r_dep + DW'(1);
          else              r_dep <= r_dep - DW'(1);
        end
        S_POP: begin
          r_res_data <= calc_tail;
          r_res_err  <= 2'd0;
          r_dep      <= '0;
        end
        S_ERR: begin
          r_res_data <= '0;
          r_dep      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tok_ready  = (r_state == S_IDLE) || (r_state == S_DRAIN);
  assign calc_apply = (r_state == S_ISSUE) || (r_state == S_POP);
  assign calc_op    = (r_state == S_ISSUE) ? r_op :
                      (r_state == S_POP) ? 3'd1 : 3'd0;
  assign calc_in    = (r_state == S_ISSUE) ? r_in : '0;
  assign calc_reset = !reset || (r_state == S_ERR);
  assign res_valid  = (r_state == S_DONE);
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer with a behavioural stack calculator
// and a result scoreboard.
`timescale 1ns/1ps
module tb_rpn_sequencer;

  logic       clk, reset;
  logic       tok_valid, tok_ready;
  logic [1:0] tok_kind;
  logic [7:0] tok_data;
  logic [7:0] calc_in, calc_tail;
  logic [2:0] calc_op;
  logic       calc_apply, calc_reset, calc_valid, calc_empty;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [1:0] res_err;

  rpn_sequencer #(.DATA_W(8), .DEPTH(5)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_data(tok_data),
    .calc_in(calc_in), .calc_op(calc_op),
    .calc_apply(calc_apply), .calc_reset(calc_reset),
    .calc_tail(calc_tail), .calc_valid(calc_valid),
    .calc_empty(calc_empty),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int acc_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural calculator: top of stack is the left operand
  logic [7:0] stk [0:15];
  int  sp = 0;
  logic cvalid = 1'b1;
  int  n_apply = 0;
  bit  ovf_seen = 1'b0;
  logic [7:0] ma, mb, mr;

  always @(posedge clk) begin
    if (calc_reset) begin
      sp     <= 0;
      cvalid <= 1'b1;
    end else if (calc_apply) begin
      n_apply <= n_apply + 1;
      if (calc_op == 3'd0) begin
        if (sp >= 5) ovf_seen <= 1'b1;
        if (sp < 16) begin
          stk[sp] <= calc_in;
          sp <= sp + 1;
        end
      end else if (calc_op == 3'd1) begin
        if (sp > 0) sp <= sp - 1;
      end else if (sp >= 2) begin
        ma = stk[sp-1];
        mb = stk[sp-2];
        mr = 8'd0;
        case (calc_op)
          3'd2: mr = ma + mb;
          3'd3: mr = ma * mb;
          3'd4: mr = ma - mb;
          3'd5: if (mb == 0) cvalid <= 1'b0; else mr = ma / mb;
          3'd6: if (mb == 0) cvalid <= 1'b0; else mr = ma % mb;
          default: cvalid <= 1'b0;
        endcase
        stk[sp-2] <= mr;
        sp <= sp - 1;
      end else begin
        cvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    calc_tail = 8'd0;
    if (sp > 0 && sp <= 16) calc_tail = stk[sp-1];
  end
  assign calc_valid = cvalid;
  assign calc_empty = (sp == 0);

  typedef struct {
    logic [7:0] d;
    logic [1:0] e;
  } exp_t;
  exp_t q[$];
  exp_t x;

  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_result data=%0d err=%0d",
                 res_data, res_err);
      end else begin
        x = q.pop_front();
        if (res_data !== x.d || res_err !== x.e)
          $display("FAIL result got d=%0d e=%0d want d=%0d e=%0d",
                   res_data, res_err, x.d, x.e);
        else
          n_pass++;
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [7:0] d);
    tok_kind  = k;
    tok_data  = d;
    tok_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        tok_valid = 1'b0;
        return;
      end
    end
    n_total++;
    $display("FAIL send_timeout kind=%0d data=%0d", k, d);
    tok_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL result_timeout pending=%0d want=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({tok_ready, calc_apply, calc_reset, res_valid} !== 4'b1010)
      $display("FAIL reset_ctl got %b want 1010",
               {tok_ready, calc_apply, calc_reset, res_valid});
    else n_pass++;
    n_total++;
    if ({calc_op, calc_in} !== 11'd0)
      $display("FAIL reset_cmd got op=%0d in=%0d want 0",
               calc_op, calc_in);
    else n_pass++;
    n_total++;
    if ({res_data, res_err} !== 10'd0)
      $display("FAIL reset_res got d=%0d e=%0d want 0",
               res_data, res_err);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int t0, t1, t2;
    send(2'd0, 8'd4); t0 = acc_cyc;
    send(2'd0, 8'd4); t1 = acc_cyc;
    send(2'd1, 8'd2); t2 = acc_cyc;
    n_total++;
    if (t1 - t0 != 3 || t2 - t1 != 3)
      $display("FAIL tok_pacing got %0d,%0d want 3,3",
               t1 - t0, t2 - t1);
    else n_pass++;
    q.push_back('{8'd8, 2'd0});
    send(2'd2, 8'd0);
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b0)
      $display("FAIL pop_cycle_valid got %b want 0", res_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b1 || calc_empty !== 1'b1)
      $display("FAIL done_latency got v=%b empty=%b want 1,1",
               res_valid, calc_empty);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_arith();
    q.push_back('{8'd12, 2'd0});
    send(2'd0, 8'd7); send(2'd0, 8'd86);
    send(2'd1, 8'd5); send(2'd2, 8'd0);
    q.push_back('{8'd2, 2'd0});
    send(2'd0, 8'd7); send(2'd0, 8'd86);
    send(2'd1, 8'd6); send(2'd2, 8'd0);
    q.push_back('{8'd0, 2'd0});
    send(2'd0, 8'd4); send(2'd0, 8'd4);
    send(2'd1, 8'd4); send(2'd2, 8'd0);
    q.push_back('{8'd42, 2'd0});
    send(2'd0, 8'd6); send(2'd0, 8'd7);
    send(2'd1, 8'd3); send(2'd2, 8'd0);
    wait_drain();
  endtask

  task automatic test_div_zero();
    int n, a0;
    q.push_back('{8'd0, 2'd3});
    send(2'd0, 8'd0); send(2'd0, 8'd86);
    send(2'd1, 8'd5);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (calc_reset) n++;
    end
    n_total++;
    if (n != 1)
      $display("FAIL err_calc_reset got %0d cycles want 1", n);
    else n_pass++;
    wait_drain();
    a0 = n_apply;
    send(2'd0, 8'd5); send(2'd1, 8'd2); send(2'd2, 8'd0);
    n_total++;
    if (n_apply != a0)
      $display("FAIL drain_apply got %0d want 0", n_apply - a0);
    else n_pass++;
    q.push_back('{8'd4, 2'd0});
    send(2'd0, 8'd4); send(2'd2, 8'd0);
    wait_drain();
    q.push_back('{8'd0, 2'd3});
    send(2'd3, 8'd0);
    send(2'd2, 8'd0);
    wait_drain();
  endtask

  task automatic test_errors();
    int a0;
    q.push_back('{8'd0, 2'd2});
    a0 = n_apply;
    for (int i = 0; i < 6; i++) send(2'd0, 8'(i + 1));
    wait_drain();
    n_total++;
    if (n_apply - a0 != 5 || ovf_seen)
      $display("FAIL overflow_applies got %0d ovf=%b want 5,0",
               n_apply - a0, ovf_seen);
    else n_pass++;
    send(2'd2, 8'd0);
    q.push_back('{8'd0, 2'd1});
    send(2'd0, 8'd4); send(2'd1, 8'd2);
    wait_drain();
    send(2'd2, 8'd0);
    q.push_back('{8'd0, 2'd1});
    send(2'd0, 8'd4); send(2'd0, 8'd4); send(2'd2, 8'd0);
    wait_drain();
    q.push_back('{8'd9, 2'd0});
    send(2'd0, 8'd9); send(2'd2, 8'd0);
    wait_drain();
  endtask

  task automatic test_hold();
    int bad;
    res_ready = 1'b0;
    q.push_back('{8'd5, 2'd0});
    send(2'd0, 8'd5); send(2'd2, 8'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    n_total++;
    if (res_valid !== 1'b1)
      $display("FAIL hold_rise got %b want 1", res_valid);
    else n_pass++;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 8'd5 || tok_ready !== 1'b0)
        bad++;
    end
    n_total++;
    if (bad != 0 || q.size() != 1)
      $display("FAIL hold_stable got bad=%0d pend=%0d want 0,1",
               bad, q.size());
    else n_pass++;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send(2'd0, 8'd4);
    send(2'd0, 8'd4);
    reset = 1'b0;
    #1;
    n_total++;
    if ({calc_apply, calc_reset, res_valid, tok_ready} !== 4'b0101)
      $display("FAIL mid_reset got %b want 0101",
               {calc_apply, calc_reset, res_valid, tok_ready});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{8'd9, 2'd0});
    send(2'd0, 8'd9); send(2'd2, 8'd0);
    wait_drain();
  endtask

  initial begin
    reset     = 1'b0;
    tok_valid = 1'b0;
    tok_kind  = 2'd0;
    tok_data  = 8'd0;
    res_ready = 1'b1;
    test_reset();
    test_add();
    test_arith();
    test_div_zero();
    test_errors();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t want finish", $time);
    $fatal(1);
  end

endmodule
